// File: rtl/ni_flit_bridge.sv
// +----------------------------------------------------------------------------+
// | ni_flit_bridge : processor <-> NoC router network interface (TX + RX)      |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module ni_flit_bridge #(
  parameter int                               FLIT_W    = 8,
  parameter int                               DATA_W    = 32,
  parameter int                               ADDR_W    = 2,
  parameter int                               LEN_W     = 3,
  parameter logic [FLIT_W-ADDR_W-LEN_W-1:0]   HDR_MARK  = 3'b101,
  parameter logic [FLIT_W-1:0]                TAIL_FLIT = {FLIT_W{1'b1}}
) (
  input  logic                clk,
  input  logic                rst,
  // processor TX
  input  logic [DATA_W-1:0]   i_tx_data,
  input  logic [ADDR_W-1:0]   i_tx_dest,
  input  logic                i_tx_valid,
  output logic                o_tx_ready,
  // router out
  output logic [FLIT_W-1:0]   o_noc_out_flit,
  output logic                o_noc_out_valid,
  input  logic                i_noc_out_ready,
  // router in
  input  logic [FLIT_W-1:0]   i_noc_in_flit,
  input  logic                i_noc_in_valid,
  output logic                o_noc_in_ready,
  // processor RX
  output logic [DATA_W-1:0]   o_rx_data,
  output logic [ADDR_W-1:0]   o_rx_dest,
  output logic [LEN_W-1:0]    o_rx_len,
  output logic                o_rx_valid,
  input  logic                i_rx_ready,
  output logic                o_rx_err
);

  localparam int               c_n_flits = DATA_W / FLIT_W;
  localparam int               c_mark_w  = FLIT_W - ADDR_W - LEN_W;
  localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);
  localparam logic [LEN_W-1:0] c_len_max = LEN_W'(c_n_flits);

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_HEAD = 2'd1;
  localparam logic [1:0] T_DATA = 2'd2;
  localparam logic [1:0] T_TAIL = 2'd3;

  localparam logic [1:0] R_HEAD = 2'd0;
  localparam logic [1:0] R_DATA = 2'd1;
  localparam logic [1:0] R_TAIL = 2'd2;
  localparam logic [1:0] R_HOLD = 2'd3;

  // ---------------------------------------------------------------- TX path
  logic [1:0]        r_tx_state;
  logic [DATA_W-1:0] r_tx_data;
  logic [ADDR_W-1:0] r_tx_dest;
  logic [LEN_W-1:0]  r_tx_len;
  logic [LEN_W-1:0]  r_tx_idx;
  logic [LEN_W-1:0]  w_tx_len;
  logic [FLIT_W-1:0] w_out_flit;
  logic              w_tx_accept;
  logic              w_out_xfer;

  // Highest non-zero flit sets the length; an all-zero word still sends one flit.
  always_comb begin
    w_tx_len = c_len_one;
    for (int k = 0; k < c_n_flits; k++) begin
      if (i_tx_data[k*FLIT_W +: FLIT_W] != '0) begin
        w_tx_len = LEN_W'(k + 1);
      end
    end
  end

  always_comb begin
    w_out_flit = '0;
    case (r_tx_state)
      T_HEAD:  w_out_flit = {HDR_MARK, r_tx_len, r_tx_dest};
      T_DATA:  w_out_flit = r_tx_data[FLIT_W-1:0];
      T_TAIL:  w_out_flit = TAIL_FLIT;
      default: w_out_flit = '0;
    endcase
  end

  assign o_tx_ready      = (r_tx_state == T_IDLE);
  assign o_noc_out_valid = (r_tx_state != T_IDLE);
  assign o_noc_out_flit  = w_out_flit;
  assign w_tx_accept     = i_tx_valid && o_tx_ready;
  assign w_out_xfer      = o_noc_out_valid && i_noc_out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= T_IDLE;
      r_tx_data  <= '0;
      r_tx_dest  <= '0;
      r_tx_len   <= '0;
      r_tx_idx   <= '0;
    end else begin
      case (r_tx_state)
        T_IDLE: begin
          if (w_tx_accept) begin
            r_tx_data  <= i_tx_data;
            r_tx_dest  <= i_tx_dest;
            r_tx_len   <= w_tx_len;
            r_tx_idx   <= '0;
            r_tx_state <= T_HEAD;
          end
        end
        T_HEAD: begin
          if (w_out_xfer) begin
            r_tx_state <= T_DATA;
          end
        end
        T_DATA: begin
          // Payload leaves LS flit first, so shifting keeps the next flit at bit 0.
          if (w_out_xfer) begin
            r_tx_data <= r_tx_data >> FLIT_W;
            r_tx_idx  <= r_tx_idx + c_len_one;
            if (r_tx_idx == (r_tx_len - c_len_one)) begin
              r_tx_state <= T_TAIL;
            end
          end
        end
        T_TAIL: begin
          if (w_out_xfer) begin
            r_tx_state <= T_IDLE;
          end
        end
        default: r_tx_state <= T_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX path
  logic [1:0]          r_rx_state;
  logic [DATA_W-1:0]   r_rx_buf;
  logic [ADDR_W-1:0]   r_rx_dest;
  logic [LEN_W-1:0]    r_rx_len;
  logic [LEN_W-1:0]    r_rx_idx;
  logic                r_rx_err;
  logic                w_in_xfer;
  logic [c_mark_w-1:0] w_hdr_mark;
  logic [LEN_W-1:0]    w_hdr_len;
  logic [ADDR_W-1:0]   w_hdr_dest;
  logic                w_hdr_ok;

  assign w_hdr_mark = i_noc_in_flit[FLIT_W-1 -: c_mark_w];
  assign w_hdr_len  = i_noc_in_flit[ADDR_W +: LEN_W];
  assign w_hdr_dest = i_noc_in_flit[ADDR_W-1:0];
  assign w_hdr_ok   = (w_hdr_mark == HDR_MARK) && (w_hdr_len != '0) &&
                      (w_hdr_len <= c_len_max);

  assign o_noc_in_ready = (r_rx_state != R_HOLD);
  assign w_in_xfer      = i_noc_in_valid && o_noc_in_ready;
  assign o_rx_valid     = (r_rx_state == R_HOLD);
  assign o_rx_data      = r_rx_buf;
  assign o_rx_dest      = r_rx_dest;
  assign o_rx_len       = r_rx_len;
  assign o_rx_err       = r_rx_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state <= R_HEAD;
      r_rx_buf   <= '0;
      r_rx_dest  <= '0;
      r_rx_len   <= '0;
      r_rx_idx   <= '0;
      r_rx_err   <= 1'b0;
    end else begin
      r_rx_err <= 1'b0;
      case (r_rx_state)
        R_HEAD: begin
          if (w_in_xfer) begin
            if (w_hdr_ok) begin
              r_rx_dest  <= w_hdr_dest;
              r_rx_len   <= w_hdr_len;
              r_rx_buf   <= '0;
              r_rx_idx   <= '0;
              r_rx_state <= R_DATA;
            end else begin
              r_rx_err <= 1'b1;
            end
          end
        end
        R_DATA: begin
          if (w_in_xfer) begin
            for (int k = 0; k < c_n_flits; k++) begin
              if (r_rx_idx == LEN_W'(k)) begin
                r_rx_buf[k*FLIT_W +: FLIT_W] <= i_noc_in_flit;
              end
            end
            r_rx_idx <= r_rx_idx + c_len_one;
            if (r_rx_idx == (r_rx_len - c_len_one)) begin
              r_rx_state <= R_TAIL;
            end
          end
        end
        R_TAIL: begin
          if (w_in_xfer) begin
            if (i_noc_in_flit == TAIL_FLIT) begin
              r_rx_state <= R_HOLD;
            end else begin
              r_rx_err   <= 1'b1;
              r_rx_state <= R_HEAD;
            end
          end
        end
        R_HOLD: begin
          if (i_rx_ready) begin
            r_rx_state <= R_HEAD;
          end
        end
        default: r_rx_state <= R_HEAD;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ni_flit_bridge.sv
// +----------------------------------------------------------------------------+
// | tb_ni_flit_bridge : scoreboard bench for the NI TX/RX flit bridge          |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_ni_flit_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_tx_data;
  logic [1:0]  i_tx_dest;
  logic        i_tx_valid;
  logic        o_tx_ready;
  logic [7:0]  o_noc_out_flit;
  logic        o_noc_out_valid;
  logic        i_noc_out_ready;
  logic [7:0]  i_noc_in_flit;
  logic        i_noc_in_valid;
  logic        o_noc_in_ready;
  logic [31:0] o_rx_data;
  logic [1:0]  o_rx_dest;
  logic [2:0]  o_rx_len;
  logic        o_rx_valid;
  logic        i_rx_ready;
  logic        o_rx_err;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  a;
    logic [2:0]  l;
  } rx_t;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_stim[$];
  rx_t        rx_exp[$];

  ni_flit_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .i_tx_data       (i_tx_data),
    .i_tx_dest       (i_tx_dest),
    .i_tx_valid      (i_tx_valid),
    .o_tx_ready      (o_tx_ready),
    .o_noc_out_flit  (o_noc_out_flit),
    .o_noc_out_valid (o_noc_out_valid),
    .i_noc_out_ready (i_noc_out_ready),
    .i_noc_in_flit   (i_noc_in_flit),
    .i_noc_in_valid  (i_noc_in_valid),
    .o_noc_in_ready  (o_noc_in_ready),
    .o_rx_data       (o_rx_data),
    .o_rx_dest       (o_rx_dest),
    .o_rx_len        (o_rx_len),
    .o_rx_valid      (o_rx_valid),
    .i_rx_ready      (i_rx_ready),
    .o_rx_err        (o_rx_err)
  );

  always #5 clk = ~clk;

  // Length scanned from the top flit down, first non-zero wins.
  function automatic int model_len(input logic [31:0] d);
    for (int k = 3; k >= 0; k--) begin
      if (d[8*k +: 8] != 8'h00) return k + 1;
    end
    return 1;
  endfunction

  task automatic push_tx_expect(input logic [31:0] d, input logic [1:0] a);
    int l;
    l = model_len(d);
    tx_exp.push_back({3'b101, 3'(l), a});
    for (int k = 0; k < l; k++) tx_exp.push_back(d[8*k +: 8]);
    tx_exp.push_back(8'hFF);
  endtask

  task automatic run_tx(input logic [31:0] d, input logic [1:0] a,
                        input int stall_at, input int stall_n);
    int xfers, exp_n, stall_left, cycles;
    tx_exp.delete();
    push_tx_expect(d, a);
    exp_n      = tx_exp.size();
    xfers      = 0;
    cycles     = 0;
    stall_left = stall_n;
    @(negedge clk);
    n_total++;
    if (o_tx_ready !== 1'b1) $display("FAIL tx_ready_idle: got %b want 1", o_tx_ready);
    else n_pass++;
    i_tx_valid = 1'b1;
    i_tx_data  = d;
    i_tx_dest  = a;
    @(negedge clk);
    i_tx_valid = 1'b0;
    i_tx_data  = '0;
    n_total++;
    if (o_tx_ready !== 1'b0) $display("FAIL tx_ready_busy: got %b want 0", o_tx_ready);
    else n_pass++;
    while (tx_exp.size() > 0 && cycles < 40) begin
      if (xfers == stall_at && stall_left > 0) begin
        i_noc_out_ready = 1'b0;
        stall_left--;
        n_total++;
        if (o_noc_out_valid !== 1'b1 || o_noc_out_flit !== tx_exp[0])
          $display("FAIL tx_hold: got valid=%b flit=%h want valid=1 flit=%h",
                   o_noc_out_valid, o_noc_out_flit, tx_exp[0]);
        else n_pass++;
      end else begin
        i_noc_out_ready = 1'b1;
        if (o_noc_out_valid === 1'b1) begin
          n_total++;
          if (o_noc_out_flit !== tx_exp[0])
            $display("FAIL tx_flit[%0d]: got %h want %h", xfers, o_noc_out_flit, tx_exp[0]);
          else n_pass++;
          void'(tx_exp.pop_front());
          xfers++;
        end
      end
      cycles++;
      @(negedge clk);
    end
    n_total++;
    if (tx_exp.size() != 0 || xfers != exp_n)
      $display("FAIL tx_count: got %0d transfers want %0d", xfers, exp_n);
    else n_pass++;
    n_total++;
    if (cycles != exp_n + stall_n)
      $display("FAIL tx_cycles: got %0d want %0d", cycles, exp_n + stall_n);
    else n_pass++;
    n_total++;
    if (o_noc_out_valid !== 1'b0 || o_tx_ready !== 1'b1)
      $display("FAIL tx_done: got valid=%b ready=%b want valid=0 ready=1",
               o_noc_out_valid, o_tx_ready);
    else n_pass++;
    tx_exp.delete();
  endtask

  task automatic run_rx(input int hold_n, input int exp_err);
    int  errs, hold_left;
    rx_t cur;
    errs      = 0;
    hold_left = hold_n;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (o_rx_err === 1'b1) errs++;
      i_rx_ready = 1'b1;
      if (o_rx_valid === 1'b1) begin
        if (rx_exp.size() == 0) begin
          n_total++;
          $display("FAIL rx_unexpected: got data=%h want no rx_valid", o_rx_data);
        end else begin
          cur = rx_exp[0];
          if (hold_left > 0) begin
            hold_left--;
            i_rx_ready = 1'b0;
            n_total++;
            if (o_noc_in_ready !== 1'b0 || {o_rx_data, o_rx_dest, o_rx_len} !== cur)
              $display("FAIL rx_hold: got in_ready=%b data=%h dest=%0d len=%0d want 0 %h %0d %0d",
                       o_noc_in_ready, o_rx_data, o_rx_dest, o_rx_len, cur.d, cur.a, cur.l);
            else n_pass++;
          end else begin
            n_total++;
            if ({o_rx_data, o_rx_dest, o_rx_len} !== cur)
              $display("FAIL rx_word: got data=%h dest=%0d len=%0d want %h %0d %0d",
                       o_rx_data, o_rx_dest, o_rx_len, cur.d, cur.a, cur.l);
            else n_pass++;
            void'(rx_exp.pop_front());
          end
        end
      end
      if (rx_stim.size() > 0) begin
        i_noc_in_valid = 1'b1;
        i_noc_in_flit  = rx_stim[0];
        if (o_noc_in_ready === 1'b1) void'(rx_stim.pop_front());
      end else begin
        i_noc_in_valid = 1'b0;
        i_noc_in_flit  = '0;
      end
    end
    i_noc_in_valid = 1'b0;
    n_total++;
    if (rx_exp.size() != 0 || rx_stim.size() != 0)
      $display("FAIL rx_drain: got %0d words %0d flits left want 0 0",
               rx_exp.size(), rx_stim.size());
    else n_pass++;
    n_total++;
    if (errs != exp_err) $display("FAIL rx_err_count: got %0d want %0d", errs, exp_err);
    else n_pass++;
    rx_exp.delete();
    rx_stim.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    n_total++;
    if (o_tx_ready !== 1'b1 || o_noc_out_valid !== 1'b0 || o_noc_out_flit !== 8'h00 ||
        o_noc_in_ready !== 1'b1 || o_rx_valid !== 1'b0 || o_rx_err !== 1'b0 ||
        o_rx_data !== 32'h0 || o_rx_dest !== 2'd0 || o_rx_len !== 3'd0)
      $display("FAIL %s: got txr=%b ov=%b of=%h inr=%b rv=%b re=%b rd=%h ra=%0d rl=%0d want 1 0 00 1 0 0 0 0 0",
               tag, o_tx_ready, o_noc_out_valid, o_noc_out_flit, o_noc_in_ready,
               o_rx_valid, o_rx_err, o_rx_data, o_rx_dest, o_rx_len);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");
  endtask

  task automatic test_tx_basic();
    run_tx(32'h000000A5, 2'd2, -1, 0);
    run_tx(32'h12345678, 2'd1, -1, 0);
    run_tx(32'h00000000, 2'd0, -1, 0);
    run_tx(32'h00010000, 2'd3, -1, 0);
    run_tx(32'hFF000000, 2'd2, -1, 0);
  endtask

  task automatic test_tx_stall();
    run_tx(32'h12345678, 2'd1, 2, 3);
  endtask

  task automatic test_rx_basic();
    rx_stim = '{8'hB1, 8'h78, 8'h56, 8'hFF, 8'h12, 8'hFF};
    rx_exp.push_back(rx_t'{d: 32'h12FF5678, a: 2'd1, l: 3'd4});
    run_rx(0, 0);
  endtask

  task automatic test_rx_errors();
    rx_stim = '{8'h26, 8'hA6, 8'hA5, 8'h00, 8'hA6, 8'hA5, 8'hFF};
    rx_exp.push_back(rx_t'{d: 32'h000000A5, a: 2'd2, l: 3'd1});
    run_rx(0, 2);
  endtask

  task automatic test_back_to_back();
    rx_stim = '{8'hB1, 8'h78, 8'h56, 8'hFF, 8'h12, 8'hFF, 8'hA6, 8'hA5, 8'hFF};
    rx_exp.push_back(rx_t'{d: 32'h12FF5678, a: 2'd1, l: 3'd4});
    rx_exp.push_back(rx_t'{d: 32'h000000A5, a: 2'd2, l: 3'd1});
    run_rx(5, 0);
  endtask

  task automatic test_concurrent();
    rx_stim = '{8'hAF, 8'h00, 8'h00, 8'h01, 8'hFF};
    rx_exp.push_back(rx_t'{d: 32'h00010000, a: 2'd3, l: 3'd3});
    fork
      run_tx(32'h00CAFE00, 2'd3, 1, 2);
      run_rx(0, 0);
    join
  endtask

  task automatic test_reset_midpacket();
    @(negedge clk);
    i_noc_out_ready = 1'b1;
    i_tx_valid      = 1'b1;
    i_tx_data       = 32'h12345678;
    i_tx_dest       = 2'd1;
    i_noc_in_valid  = 1'b1;
    i_noc_in_flit   = 8'hB1;
    @(negedge clk);
    i_tx_valid    = 1'b0;
    i_noc_in_flit = 8'h78;
    n_total++;
    if (o_noc_out_flit !== 8'hB1) $display("FAIL mid_hdr: got %h want b1", o_noc_out_flit);
    else n_pass++;
    @(negedge clk);
    i_noc_in_flit = 8'h56;
    n_total++;
    if (o_noc_out_flit !== 8'h78) $display("FAIL mid_78: got %h want 78", o_noc_out_flit);
    else n_pass++;
    @(negedge clk);
    rst            = 1'b1;
    i_noc_in_valid = 1'b0;
    i_noc_in_flit  = '0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    run_tx(32'h12345678, 2'd1, -1, 0);
    rx_stim = '{8'hB1, 8'h78, 8'h56, 8'hFF, 8'h12, 8'hFF};
    rx_exp.push_back(rx_t'{d: 32'h12FF5678, a: 2'd1, l: 3'd4});
    run_rx(0, 0);
  endtask

  initial begin
    rst             = 1'b1;
    i_tx_data       = '0;
    i_tx_dest       = '0;
    i_tx_valid      = 1'b0;
    i_noc_out_ready = 1'b1;
    i_noc_in_flit   = '0;
    i_noc_in_valid  = 1'b0;
    i_rx_ready      = 1'b1;
    test_reset();
    test_tx_basic();
    test_tx_stall();
    test_rx_basic();
    test_rx_errors();
    test_back_to_back();
    test_concurrent();
    test_reset_midpacket();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
